// File: rtl/data_mem_pkg.sv
// Shared types and address decode for the data memory block.
package data_mem_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int BYTE_OFFSET_BITS = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] index;
    logic        bad;
  } decode_t;

  // The limit is formed in 33 bits so that BASE_ADDR + size can never wrap to a small value.
  function automatic decode_t decode_addr(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] depth_words);
    decode_t     d;
    logic [32:0] limit;
    logic [31:0] offset;
    limit   = {1'b0, base} + (33'(depth_words) << BYTE_OFFSET_BITS);
    offset  = addr - base;
    d.index = offset >> BYTE_OFFSET_BITS;
    d.bad   = (addr[BYTE_OFFSET_BITS-1:0] != '0) || (addr < base) || ({1'b0, addr} >= limit);
    return d;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage with one write port and one registered, write-first read port.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]          rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value when no read is issued; a same-word store is forwarded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/data_mem.sv
// Data memory front end: post-reset clear sweep, address decode, done/valid/error pulses.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Data_mem_write_enable,
  input  logic [31:0]           Data_mem_write_addr,
  input  logic [DATA_WIDTH-1:0] Data_mem_write_data,
  input  logic                  Data_mem_read_enable,
  input  logic [31:0]           Data_mem_read_addr,
  output logic [DATA_WIDTH-1:0] Data_mem_read_data,
  output logic                  Data_mem_read_valid,
  output logic                  Data_mem_write_done,
  output logic                  Data_mem_error,
  output logic                  Data_mem_ready
);

  localparam int             AW       = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0]  LAST_PTR = AW'(DEPTH_WORDS - 1);

  state_t                state_q, state_d;
  logic [AW-1:0]         clear_ptr;
  decode_t               w_dec, r_dec;
  logic                  w_bad, r_bad, ready, w_go, r_go;
  logic                  arr_we;
  logic [AW-1:0]         arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic                  vld_p1, done_p1, err_p1;

  // Index bits above the array width can only be set for out-of-range addresses; fold them in anyway.
  assign w_dec = decode_addr(Data_mem_write_addr, BASE_ADDR, 32'(DEPTH_WORDS));
  assign r_dec = decode_addr(Data_mem_read_addr,  BASE_ADDR, 32'(DEPTH_WORDS));
  assign w_bad = w_dec.bad | (|(w_dec.index >> AW));
  assign r_bad = r_dec.bad | (|(r_dec.index >> AW));

  assign ready = (state_q == READY);
  assign w_go  = ready & Data_mem_write_enable & ~w_bad;
  assign r_go  = ready & Data_mem_read_enable  & ~r_bad;

  always_comb begin
    state_d   = state_q;
    arr_we    = 1'b0;
    arr_waddr = w_dec.index[AW-1:0];
    arr_wdata = Data_mem_write_data;
    case (state_q)
      CLEAR: begin
        arr_we    = 1'b1;
        arr_waddr = clear_ptr;
        arr_wdata = '0;
        if (clear_ptr == LAST_PTR) state_d = READY;
      end
      READY: arr_we = w_go;
      default: state_d = CLEAR;
    endcase
    if (!reset) arr_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clear_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clear_ptr <= clear_ptr + 1'b1;
    end
  end

  // ---- stage p1: registered response pulses ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      vld_p1  <= r_go;
      done_p1 <= w_go;
      err_p1  <= ready & ((Data_mem_write_enable & w_bad) | (Data_mem_read_enable & r_bad));
    end
  end

  data_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (r_go),
    .raddr (r_dec.index[AW-1:0]),
    .rdata (Data_mem_read_data)
  );

  assign Data_mem_read_valid = vld_p1;
  assign Data_mem_write_done = done_p1;
  assign Data_mem_error      = err_p1;
  assign Data_mem_ready      = ready;

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: behavioural model plus per-cycle compare, directed and random traffic.
module tb_data_mem;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk, reset;
  logic        we, re;
  logic [31:0] wa, wd, ra;
  logic [31:0] rdata;
  logic        valid, done, err, ready;

  data_mem #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .Data_mem_write_enable(we),
    .Data_mem_write_addr  (wa),
    .Data_mem_write_data  (wd),
    .Data_mem_read_enable (re),
    .Data_mem_read_addr   (ra),
    .Data_mem_read_data   (rdata),
    .Data_mem_read_valid  (valid),
    .Data_mem_write_done  (done),
    .Data_mem_error       (err),
    .Data_mem_ready       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory reads as zero after any reset, ready after DEPTH un-reset edges.
  logic [31:0] mdl_mem [DEPTH];
  int          sweep_cnt;
  logic [31:0] e_rdata;
  logic        e_valid, e_done, e_err, e_ready;
  bit          started = 0;

  function automatic bit good_addr(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && (longint'(a) < longint'(BASE) + 4 * DEPTH);
  endfunction

  always @(posedge clk) begin
    bit wg, rg;
    started = 1;
    wg = good_addr(wa);
    rg = good_addr(ra);
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
      sweep_cnt = 0;
      e_rdata = 32'h0; e_valid = 0; e_done = 0; e_err = 0;
    end else if (sweep_cnt < DEPTH) begin
      sweep_cnt++;
      e_valid = 0; e_done = 0; e_err = 0;
    end else begin
      e_done = we && wg;
      e_err  = (we && !wg) || (re && !rg);
      if (we && wg) mdl_mem[int'((wa - BASE) >> 2)] = wd;
      e_valid = re && rg;
      if (re && rg) e_rdata = mdl_mem[int'((ra - BASE) >> 2)];
    end
    e_ready = (sweep_cnt == DEPTH);
  end

  always @(negedge clk) begin
    if (started) begin
      chk("read_data",  rdata,      e_rdata);
      chk("read_valid", 32'(valid), 32'(e_valid));
      chk("write_done", 32'(done),  32'(e_done));
      chk("error",      32'(err),   32'(e_err));
      chk("ready",      32'(ready), 32'(e_ready));
    end
  end

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic r, input logic [31:0] rda);
    we = w; wa = a; wd = d; re = r; ra = rda;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_ready(output int n, output int pulses);
    n = 0;
    pulses = 0;
    while (!ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (valid || done || err) pulses++;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 15);
    if (sel == 0) return {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
    if (sel == 1) return ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
    if (sel < 9)  return BASE + 32'($urandom_range(0, 15)) * 4;
    return BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
  endfunction

  int n, pulses;

  initial begin
    reset = 1'b0; we = 0; re = 0; wa = 0; wd = 0; ra = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);

    // Requests during the sweep must be ignored.
    we = 1; wa = 32'h80; wd = 32'h5555_AAAA; re = 1; ra = 32'h80;
    wait_ready(n, pulses);
    chk("sweep_cycles", n, 32'd1024);
    chk("clear_pulses", pulses, 32'd0);

    drive(0, 0, 0, 1, 32'h000); chk("rd0_valid", 32'(valid), 32'h1); chk("rd0_data", rdata, 32'h0);
    drive(0, 0, 0, 1, 32'h7FC); chk("rd7fc_data", rdata, 32'h0);
    drive(0, 0, 0, 1, 32'hFFC); chk("rdffc_data", rdata, 32'h0);
    drive(0, 0, 0, 1, 32'h080); chk("rd80_data", rdata, 32'h0);

    drive(1, 32'h10, 32'hDEADBEEF, 0, 0); chk("st10_done", 32'(done), 32'h1);
    drive(0, 0, 0, 1, 32'h10);
    chk("ld10_data", rdata, 32'hDEADBEEF); chk("ld10_done", 32'(done), 32'h0);

    drive(1, 32'h20, 32'h12345678, 1, 32'h20);
    chk("wf_data", rdata, 32'h12345678); chk("wf_valid", 32'(valid), 32'h1);
    chk("wf_done", 32'(done), 32'h1);

    drive(1, 32'h13, 32'hFFFF_0000, 0, 0);
    chk("mis_err", 32'(err), 32'h1); chk("mis_done", 32'(done), 32'h0);
    drive(0, 0, 0, 1, 32'h1000);
    chk("oor_err", 32'(err), 32'h1); chk("oor_valid", 32'(valid), 32'h0);
    chk("oor_hold", rdata, 32'h12345678);
    drive(0, 0, 0, 1, 32'h10); chk("w10_kept", rdata, 32'hDEADBEEF);

    drive(1, 32'h3, 32'h1, 1, 32'h2000); chk("bb_err", 32'(err), 32'h1);
    idle(); chk("err_width", 32'(err), 32'h0);

    drive(1, 32'h30, 32'h1, 0, 0); chk("b2b_done0", 32'(done), 32'h1);
    drive(1, 32'h34, 32'h2, 0, 0); chk("b2b_done1", 32'(done), 32'h1);
    idle(); chk("b2b_done2", 32'(done), 32'h0);

    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) begin
        we = $urandom_range(0, 1); re = $urandom_range(0, 1);
        pulse_reset();
      end
      drive(1'($urandom_range(0, 2) == 0), rand_addr(), $urandom,
            1'($urandom_range(0, 1)), rand_addr());
    end
    idle();

    drive(1, 32'h40, 32'hA5A5A5A5, 0, 0); chk("st40_done", 32'(done), 32'h1);
    pulse_reset();
    repeat (500) idle();
    chk("mid_ready", 32'(ready), 32'h0);
    pulse_reset();
    wait_ready(n, pulses);
    chk("resweep_cycles", n, 32'd1024);
    drive(0, 0, 0, 1, 32'h40); chk("ld40_zero", rdata, 32'h0); chk("ld40_valid", 32'(valid), 32'h1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Word-organised data memory that answers the memory stage's load/store requests in the single-cycle core.
- Sits between the memory stage and on-chip storage:
  - Accepts a one-cycle write strobe and a level read request.
  - Returns registered read data and a write-done pulse.
  - Flags bad accesses.
- After every reset it sweeps the array to zero before accepting traffic.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; must be a power of two, at least 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- Data_mem_write_enable  input  1  store strobe, one cycle per store
- Data_mem_write_addr  input  32  store byte address
- Data_mem_write_data  input  32  store data
- Data_mem_read_enable  input  1  load request, level; sampled every cycle
- Data_mem_read_addr  input  32  load byte address
- Data_mem_read_data  output  32  registered load data
- Data_mem_read_valid  output  1  Data_mem_read_data is valid this cycle
- Data_mem_write_done  output  1  one-cycle pulse: the store was committed
- Data_mem_error  output  1  one-cycle pulse: a bad access was rejected
- Data_mem_ready  output  1  clear sweep finished; requests are honoured

Behaviour:
- Reset is synchronous and active-low: sampled only at the rising edge of clk while reset=0.
- On reset, all outputs are driven to 0 and the FSM enters CLEAR with clear_ptr=0.
- Reset asserted mid-sweep or mid-access restarts CLEAR from 0. Any in-flight store or load is dropped and produces no pulse.
- FSM CLEAR:
  - Writes 0 to word clear_ptr each cycle, then increments clear_ptr.
  - After word DEPTH_WORDS-1, moves to READY; Data_mem_ready=1 from the next cycle.
  - The sweep therefore takes exactly DEPTH_WORDS cycles after reset deasserts.
  - While in CLEAR, write_enable and read_enable are ignored: no array write, no valid, no done, no error.
- FSM READY: stays in READY until reset.
- Address decode (READY only):
  - index = (addr - BASE_ADDR) >> 2.
  - An access is bad if addr[1:0] != 0, or addr < BASE_ADDR, or addr >= BASE_ADDR + DEPTH_WORDS*4.
- Store (READY, write_enable=1):
  - Good address: the array word is written at this edge, and Data_mem_write_done=1 the next cycle for one cycle.
  - Bad address: the array is unchanged, write_done stays 0, and Data_mem_error=1 the next cycle.
- Load (READY, read_enable=1):
  - Good address: Data_mem_read_data = array[index] and Data_mem_read_valid=1 on the next cycle. Latency is 1 cycle.
  - Holding read_enable high gives one result per cycle, each tracking that cycle's address.
  - Bad address: read_valid=0, error=1 the next cycle, and read_data holds its previous value.
- Cycles with read_enable=0: read_valid=0 next cycle; read_data holds its last value, it is not zeroed.
- Simultaneous store and load to the same good word: the load returns the new store data (write-first).
  - Store and load to different words: both complete independently.
- Simultaneous bad store and bad load: a single error pulse.
  - One bad and one good access: the good one completes; error pulses for the bad one.
- All pulses are exactly one cycle wide. Back-to-back stores on consecutive cycles give back-to-back write_done pulses.
- Width rules:
  - Address subtraction is 32-bit unsigned; the range check uses a 33-bit compare so BASE_ADDR+size cannot wrap.
  - clear_ptr is clog2(DEPTH_WORDS) bits.

Decomposition:
- Package data_mem_pkg:
  - DATA_WIDTH=32, BYTE_OFFSET_BITS=2.
  - FSM state enum {CLEAR, READY}.
  - A function returning index plus a bad-access flag from an address, BASE_ADDR and DEPTH_WORDS.
- Sub-module data_mem_array:
  - DEPTH_WORDS x 32 storage with one write port and one registered read port, write-first on collision.
  - The FSM muxes the clear port onto its write port.
- data_mem keeps the FSM, decode, pulse generation and error logic.

Test Plan:
- Reset 1 cycle, then release -> ready=0 for exactly 1024 cycles, then 1; reads of 0x000, 0x7FC and 0xFFC return 0 with valid=1 one cycle after the request.
- Store 0xDEADBEEF to 0x10 -> write_done pulses 1 cycle later; load 0x10 -> read_data=0xDEADBEEF, valid=1 at +1 cycle.
- Same cycle: store 0x12345678 to 0x20 and load 0x20 -> next cycle read_data=0x12345678, valid=1, write_done=1.
- Store to 0x13 (misaligned), then load 0x1000 (out of range, DEPTH=1024) -> error pulses on each, no done, no valid; word 0x10 is unchanged.
- Write/read requests during the CLEAR sweep -> no pulses of any kind; the target word reads 0 after ready.
- Store 0xA5A5A5A5 to 0x40, assert reset mid-sweep at cycle 500 -> sweep restarts (1024 more cycles); 0x40 reads 0 afterward.
